// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU and GPU requesters.
// Each requester has a read channel and a write channel. Grants are round-robin
// between the two ports, and a write beats a read within the same port. Every
// access takes the fixed sequence IDLE -> ISSUE -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_read_addr,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_read_ack,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_write_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_write_ack,
  input  logic              gpu_read,
  input  logic [ADDR_W-1:0] gpu_read_addr,
  output logic [DATA_W-1:0] gpu_read_data,
  output logic              gpu_read_ack,
  input  logic              gpu_write,
  input  logic [ADDR_W-1:0] gpu_write_addr,
  input  logic [DATA_W-1:0] gpu_write_data,
  output logic              gpu_write_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic              last_gpu;   // 1 when the GPU holds the most recent grant
  logic              op_gpu;     // port tag of the access in flight
  logic              op_write;   // op tag of the access in flight
  logic [DATA_W-1:0] cpu_read_hold;
  logic [DATA_W-1:0] gpu_read_hold;

  logic              cpu_pending;
  logic              gpu_pending;
  logic              grant_gpu;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign cpu_pending = cpu_read | cpu_write;
  assign gpu_pending = gpu_read | gpu_write;
  // The GPU wins when it is the only port pending, or on a tie when the CPU was served last.
  assign grant_gpu   = gpu_pending & (~cpu_pending | ~last_gpu);

  // Pick the channel of the winning port. A write goes ahead of a read on the same port.
  always_comb begin
    if (grant_gpu) begin
      sel_write = gpu_write;
      sel_addr  = gpu_write ? gpu_write_addr : gpu_read_addr;
      sel_wdata = gpu_write_data;
    end else begin
      sel_write = cpu_write;
      sel_addr  = cpu_write ? cpu_write_addr : cpu_read_addr;
      sel_wdata = cpu_write_data;
    end
  end

  // ram_rdata comes straight from the RAM output register and is valid during RESP.
  // It is forwarded while the read ack is high; the hold register keeps it afterwards.
  assign cpu_read_data = cpu_read_ack ? ram_rdata : cpu_read_hold;
  assign gpu_read_data = gpu_read_ack ? ram_rdata : gpu_read_hold;

  // Access sequencer. The acks are registered on entry to RESP, so each ack is visible exactly in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_gpu      <= 1'b1;
      op_gpu        <= 1'b0;
      op_write      <= 1'b0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      busy          <= 1'b0;
      cpu_read_ack  <= 1'b0;
      cpu_write_ack <= 1'b0;
      gpu_read_ack  <= 1'b0;
      gpu_write_ack <= 1'b0;
      cpu_read_hold <= '0;
      gpu_read_hold <= '0;
    end else begin
      cpu_read_ack  <= 1'b0;
      cpu_write_ack <= 1'b0;
      gpu_read_ack  <= 1'b0;
      gpu_write_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_pending | gpu_pending) begin
            last_gpu  <= grant_gpu;
            op_gpu    <= grant_gpu;
            op_write  <= sel_write;
            ram_we    <= sel_write;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en        <= 1'b0;
          cpu_read_ack  <= ~op_gpu & ~op_write;
          cpu_write_ack <= ~op_gpu &  op_write;
          gpu_read_ack  <=  op_gpu & ~op_write;
          gpu_write_ack <=  op_gpu &  op_write;
          state         <= RESP;
        end
        RESP: begin
          if (!op_write) begin
            if (op_gpu) gpu_read_hold <= ram_rdata;
            else        cpu_read_hold <= ram_rdata;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level reference model. Channels are numbered
// 0 = cpu_read, 1 = cpu_write, 2 = gpu_read, 3 = gpu_write.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]    req;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wdat [4];
  logic [3:0]    ack;
  logic [DW-1:0] rdat [2];
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(req[0]), .cpu_read_addr(addr[0]), .cpu_read_data(rdat[0]), .cpu_read_ack(ack[0]),
    .cpu_write(req[1]), .cpu_write_addr(addr[1]), .cpu_write_data(wdat[1]), .cpu_write_ack(ack[1]),
    .gpu_read(req[2]), .gpu_read_addr(addr[2]), .gpu_read_data(rdat[1]), .gpu_read_ack(ack[2]),
    .gpu_write(req[3]), .gpu_write_addr(addr[3]), .gpu_write_data(wdat[3]), .gpu_write_ack(ack[3]),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 'h200) ? 8'hA2 : 8'(i * 37 + 11);
  endfunction

  // RAM with registered read; preloaded while init_en is high
  logic          init_en;
  logic [DW-1:0] ram [4096];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model: the most recent grant happened at edge g on channel g_ch.
  // Its strobe follows that edge, its ack follows edge g+1, and the next grant can occur at edge g+3.
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            g = 0;
  bit            g_valid;
  int            g_ch;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  bit            last;          // 1 = GPU granted last
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] ref_mem [4096];
  int            since [4];
  int            dut_order [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g_valid   = 0;
    last      = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  function automatic bit in_issue();
    return g_valid && cyc == g;
  endfunction

  function automatic bit in_resp();
    return g_valid && cyc == g + 1;
  endfunction

  task automatic check_outputs();
    chk("ram_en", {31'd0, ram_en}, {31'd0, in_issue()});
    chk("busy", {31'd0, busy}, {31'd0, in_issue() || in_resp()});
    for (int i = 0; i < 4; i++)
      chk($sformatf("ack%0d", i), {31'd0, ack[i]}, {31'd0, in_resp() && g_ch == i});
    chk("cpu_read_data", {24'd0, rdat[0]}, {24'd0, exp_rd[0]});
    chk("gpu_read_data", {24'd0, rdat[1]}, {24'd0, exp_rd[1]});
    if (in_issue()) begin
      chk("ram_addr", {20'd0, ram_addr}, {20'd0, g_addr});
      chk("ram_we", {31'd0, ram_we}, {31'd0, g_ch[0]});
      if (g_ch[0]) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, g_wdata});
    end
  endtask

  // Advance one clock edge, update the model from the inputs sampled at that edge, and check the outputs.
  task automatic tick();
    logic [3:0]    s_req;
    logic [AW-1:0] s_addr [4];
    logic [DW-1:0] s_wd [4];
    bit            cp, gp;
    int            p;
    s_req = req;
    for (int i = 0; i < 4; i++) begin
      s_addr[i] = addr[i];
      s_wd[i]   = wdat[i];
    end
    @(posedge clk);
    cyc++;
    if (g_valid && cyc == g + 1) begin
      if (g_ch[0]) ref_mem[g_addr] = g_wdata;
      else         exp_rd[g_ch >> 1] = ref_mem[g_addr];
    end
    if (!g_valid || cyc >= g + 3) begin
      cp = s_req[0] | s_req[1];
      gp = s_req[2] | s_req[3];
      if (cp || gp) begin
        p       = (cp && gp) ? (last ? 0 : 1) : (gp ? 1 : 0);
        g_ch    = 2 * p + (s_req[2*p+1] ? 1 : 0);
        g_addr  = s_addr[g_ch];
        g_wdata = s_wd[g_ch];
        g       = cyc;
        g_valid = 1;
        last    = (p == 1);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic new_req(int i);
    req[i]   = 1'b1;
    addr[i]  = 12'h300 | 12'($urandom_range(0, 15));
    wdat[i]  = 8'($urandom);
    since[i] = cyc + 1;
  endtask

  // mode 0: drop on ack; mode 1: replace the request on ack (continuous); mode 2: random traffic
  task automatic run(int n, int mode);
    int w;
    for (int k = 0; k < n; k++) begin
      tick();
      if (ack[0] | ack[1]) dut_order.push_back(0);
      if (ack[2] | ack[3]) begin
        dut_order.push_back(1);
        if (mode == 1) begin
          w = (cyc - 1) - since[ack[3] ? 3 : 2];
          chk("gpu_wait_le6", {31'd0, w <= 6}, 32'd1);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && in_resp() && g_ch == i) begin
          req[i] = 1'b0;
          if (mode == 1) new_req(i);
        end else if (mode == 2) begin
          if (req[i] && !(g_valid && (in_issue() || in_resp()) && g_ch == i)) begin
            if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            new_req(i);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    init_en = 1'b1;
    req     = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      wdat[i] = '0;
      since[i] = 0;
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    model_reset();

    // Reset held with cpu_read high: nothing may move
    req[0]  = 1'b1;
    addr[0] = 12'h123;
    repeat (3) begin
      @(posedge clk);
      #1;
      init_en = 1'b0;
      chk("rst_acks", {28'd0, ack}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
      chk("rst_cpu_rd", {24'd0, rdat[0]}, 32'd0);
    end
    rst_n = 1'b1;
    run(1, 0);
    chk("first_en", {31'd0, ram_en}, 32'd1);
    chk("first_addr", {20'd0, ram_addr}, 32'h123);
    run(3, 0);

    // Single CPU read of 0x200
    req[0] = 1'b1; addr[0] = 12'h200;
    run(1, 0);
    chk("rd200_we", {31'd0, ram_we}, 32'd0);
    run(1, 0);
    chk("rd200_data", {24'd0, rdat[0]}, 32'hA2);
    run(2, 0);

    // Single GPU write of 0xFF to 0xF00, read back by the CPU
    req[3] = 1'b1; addr[3] = 12'hF00; wdat[3] = 8'hFF;
    run(1, 0);
    chk("wrF00_we", {31'd0, ram_we}, 32'd1);
    run(2, 0);
    req[0] = 1'b1; addr[0] = 12'hF00;
    run(3, 0);
    chk("rdF00_data", {24'd0, rdat[0]}, 32'hFF);

    // Simultaneous CPU read and GPU write right after reset: CPU goes first
    rst_n = 1'b0; #2; model_reset(); rst_n = 1'b1;
    req[0] = 1'b1; addr[0] = 12'h050;
    req[3] = 1'b1; addr[3] = 12'h300; wdat[3] = 8'h3C;
    run(2, 0);
    chk("sim_cpu_ack", {31'd0, ack[0]}, 32'd1);
    run(2, 0);
    chk("sim_gpu_en", {31'd0, ram_en}, 32'd1);
    chk("sim_gpu_addr", {20'd0, ram_addr}, 32'h300);
    run(1, 0);
    chk("sim_gpu_ack", {31'd0, ack[3]}, 32'd1);
    run(1, 0);

    // Fairness: both ports continuously requesting for 12 accesses
    dut_order.delete();
    new_req(0);
    new_req(2);
    run(36, 1);
    chk("fair_count", dut_order.size(), 32'd12);
    for (int i = 1; i < dut_order.size(); i++)
      chk($sformatf("fair_alt%0d", i), {31'd0, dut_order[i] != dut_order[i-1]}, 32'd1);
    run(9, 0);

    // Same-port write and read of 0x210: the write is served first
    req[1] = 1'b1; addr[1] = 12'h210; wdat[1] = 8'h55;
    req[0] = 1'b1; addr[0] = 12'h210;
    run(2, 0);
    chk("sp_write_ack", {31'd0, ack[1]}, 32'd1);
    chk("sp_no_read_ack", {31'd0, ack[0]}, 32'd0);
    run(4, 0);
    chk("sp_read_data", {24'd0, rdat[0]}, 32'h55);
    run(1, 0);

    // Abort: reset during ISSUE of a CPU read, then the held request is served again
    req[0] = 1'b1; addr[0] = 12'h060;
    run(1, 0);
    chk("abort_in_issue", {31'd0, ram_en}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_acks", {28'd0, ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cpu_rd", {24'd0, rdat[0]}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    run(2, 0);
    chk("abort_reserved_ack", {31'd0, ack[0]}, 32'd1);
    chk("abort_reserved_data", {24'd0, rdat[0]}, {24'd0, init_val('h060)});
    run(1, 0);

    // Random traffic with early drops and re-requests
    run(600, 2);
    req = '0;
    run(4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
